// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, forwarding and write-back control for a 5-stage in-order pipeline
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_*_i                     decode-stage instruction fields (valid, sources, dest, kind flags)
//   mem_redirect_i             taken branch/jump resolved in MEM
//   stall_o                    hold PC and IF/ID (load-use hazard)
//   flush_id_o                 replace IF/ID with a bubble (redirect)
//   ex_a_sel_o, ex_b_sel_o     EX operand selects: 00 reg, 01 MEM ALU, 10 WB data, 11 zero/imm
//   rf_w_o, rf_wen_o           register-file write index / enable from WB
module pipeline_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] id_rd_i,
    input  logic       id_reg_write_i,
    input  logic       id_load_i,
    input  logic       id_a_zero_i,
    input  logic       id_b_imm_i,
    input  logic       mem_redirect_i,
    output logic       stall_o,
    output logic       flush_id_o,
    output logic [1:0] ex_a_sel_o,
    output logic [1:0] ex_b_sel_o,
    output logic [4:0] rf_w_o,
    output logic       rf_wen_o
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rd;
        logic       we;
        logic       load;
        logic       a_zero;
        logic       b_imm;
    } ex_t;
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
    } st_t;
    ex_t ex_q, ex_d;
    st_t mem_q, mem_d, wb_q, wb_d;
    logic hazard;
    function automatic logic writes(input st_t s, input logic [4:0] r);
        return s.valid & s.we & (s.rd == r) & (r != 5'd0);
    endfunction
    always_comb begin
        hazard = ex_q.valid & ex_q.load & ex_q.we & (ex_q.rd != 5'd0) & id_valid_i &
                 ((id_use_rs1_i & (id_rs1_i == ex_q.rd)) | (id_use_rs2_i & (id_rs2_i == ex_q.rd)));
        // Redirect squashes the decode slot anyway, so it overrides the load-use hold.
        stall_o    = hazard & ~mem_redirect_i;
        flush_id_o = mem_redirect_i;
        ex_d = '0;
        if (id_valid_i & ~hazard & ~mem_redirect_i)
            ex_d = '{valid: 1'b1, rs1: id_rs1_i, rs2: id_rs2_i, use_rs1: id_use_rs1_i,
                     use_rs2: id_use_rs2_i, rd: id_rd_i, we: id_reg_write_i, load: id_load_i,
                     a_zero: id_a_zero_i, b_imm: id_b_imm_i};
        // The instruction younger than the redirecting one is squashed on its way into MEM.
        mem_d = mem_redirect_i ? '0 : '{valid: ex_q.valid, rd: ex_q.rd, we: ex_q.we};
        wb_d  = mem_q;
        // A load never sits in MEM with a dependent in EX: the load-use stall inserts a bubble.
        ex_a_sel_o = ex_q.a_zero ? 2'b11 :
                     (ex_q.use_rs1 & writes(mem_q, ex_q.rs1)) ? 2'b01 :
                     (ex_q.use_rs1 & writes(wb_q, ex_q.rs1)) ? 2'b10 : 2'b00;
        ex_b_sel_o = ex_q.b_imm ? 2'b11 :
                     (ex_q.use_rs2 & writes(mem_q, ex_q.rs2)) ? 2'b01 :
                     (ex_q.use_rs2 & writes(wb_q, ex_q.rs2)) ? 2'b10 : 2'b00;
        rf_w_o   = wb_q.rd;
        rf_wen_o = wb_q.valid & wb_q.we & (wb_q.rd != 5'd0);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl hazard/forward/write-back control
module tb_pipeline_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid_i, id_use_rs1_i, id_use_rs2_i, id_reg_write_i;
    logic       id_load_i, id_a_zero_i, id_b_imm_i, mem_redirect_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       stall_o, flush_id_o, rf_wen_o;
    logic [1:0] ex_a_sel_o, ex_b_sel_o;
    logic [4:0] rf_w_o;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
        .id_reg_write_i(id_reg_write_i), .id_load_i(id_load_i),
        .id_a_zero_i(id_a_zero_i), .id_b_imm_i(id_b_imm_i),
        .mem_redirect_i(mem_redirect_i),
        .stall_o(stall_o), .flush_id_o(flush_id_o),
        .ex_a_sel_o(ex_a_sel_o), .ex_b_sel_o(ex_b_sel_o),
        .rf_w_o(rf_w_o), .rf_wen_o(rf_wen_o)
    );

    always #5 clk = ~clk;

    localparam int STALL = 0, FLUSH = 1, ASEL = 2, BSEL = 3, WEN = 4, WIDX = 5;

    typedef struct {
        int    at;
        string tag;
        int    sig;
        int    val;
    } sb_t;
    sb_t sb[$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int observe(input int s);
        case (s)
            STALL:   return int'(stall_o);
            FLUSH:   return int'(flush_id_o);
            ASEL:    return int'(ex_a_sel_o);
            BSEL:    return int'(ex_b_sel_o);
            WEN:     return int'(rf_wen_o);
            default: return int'(rf_w_o);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].at == cyc) begin
                check(sb[i].tag, observe(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
    end

    task automatic exp_at(input int at, input string tag, input int sig, input int v);
        sb.push_back('{at, tag, sig, v});
    endtask

    task automatic exp_reset(input int at, input string tag);
        exp_at(at, {tag, "_stall"}, STALL, 0);
        exp_at(at, {tag, "_flush"}, FLUSH, 0);
        exp_at(at, {tag, "_asel"}, ASEL, 0);
        exp_at(at, {tag, "_bsel"}, BSEL, 0);
        exp_at(at, {tag, "_rfw"}, WIDX, 0);
        exp_at(at, {tag, "_rfwen"}, WEN, 0);
    endtask

    task automatic ins(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic az, input logic bi,
                       input logic redir);
        id_valid_i = v; id_rs1_i = r1; id_rs2_i = r2; id_use_rs1_i = u1; id_use_rs2_i = u2;
        id_rd_i = rd; id_reg_write_i = we; id_load_i = ld; id_a_zero_i = az; id_b_imm_i = bi;
        mem_redirect_i = redir;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        ins(1, r1, r2, 1, 1, rd, 1, 0, 0, 0, 0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] r1);
        ins(1, r1, 0, 1, 0, rd, 1, 1, 0, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        nops(1);
        exp_reset(cyc, "rst");
        nops(1);
        rst_n = 1'b1;
        exp_reset(cyc, "post_rst");
        nops(2);

        c = cyc;
        exp_at(c + 1, "b2b_stall", STALL, 0);
        exp_at(c + 1, "b2b_first_asel", ASEL, 0);
        exp_at(c + 2, "b2b_asel", ASEL, 1);
        exp_at(c + 2, "b2b_bsel", BSEL, 1);
        exp_at(c + 3, "b2b_rfwen", WEN, 1);
        exp_at(c + 3, "b2b_rfw", WIDX, 5);
        exp_at(c + 4, "b2b_rfw2", WIDX, 6);
        add(5, 1, 2);
        add(6, 5, 5);
        nops(4);

        c = cyc;
        exp_at(c + 3, "wbfwd_asel", ASEL, 2);
        exp_at(c + 3, "wbfwd_bsel", BSEL, 0);
        add(5, 1, 2);
        nops(1);
        add(7, 5, 1);
        nops(4);

        c = cyc;
        exp_at(c + 3, "prio_asel", ASEL, 1);
        exp_at(c + 3, "prio_bsel", BSEL, 0);
        add(5, 1, 2);
        add(5, 3, 4);
        add(12, 5, 6);
        nops(4);

        c = cyc;
        exp_at(c + 1, "lu_stall", STALL, 1);
        exp_at(c + 1, "lu_flush", FLUSH, 0);
        exp_at(c + 1, "lu_lw_bsel", BSEL, 3);
        exp_at(c + 2, "lu_stall_rel", STALL, 0);
        exp_at(c + 2, "lu_bubble_asel", ASEL, 0);
        exp_at(c + 2, "lu_bubble_bsel", BSEL, 0);
        exp_at(c + 3, "lu_asel", ASEL, 2);
        exp_at(c + 3, "lu_bsel", BSEL, 0);
        exp_at(c + 3, "lu_rfwen", WEN, 1);
        exp_at(c + 3, "lu_rfw", WIDX, 8);
        exp_at(c + 4, "lu_bubble_wen", WEN, 0);
        exp_at(c + 5, "lu_add_wen", WEN, 1);
        exp_at(c + 5, "lu_add_rfw", WIDX, 9);
        lw(8, 3);
        add(9, 8, 2);
        add(9, 8, 2);
        nops(5);

        c = cyc;
        exp_at(c + 2, "x0_asel", ASEL, 0);
        exp_at(c + 2, "x0_bsel", BSEL, 3);
        exp_at(c + 3, "x0_rfwen", WEN, 0);
        ins(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0);
        ins(1, 0, 0, 1, 0, 11, 1, 0, 0, 1, 0);
        nops(4);

        c = cyc;
        exp_at(c + 1, "lui_asel", ASEL, 3);
        exp_at(c + 1, "lui_bsel", BSEL, 3);
        ins(1, 0, 0, 0, 0, 10, 1, 0, 1, 1, 0);
        nops(4);

        c = cyc;
        exp_at(c + 1, "novalid_stall", STALL, 0);
        exp_at(c + 2, "novalid_asel", ASEL, 0);
        lw(8, 3);
        ins(0, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0);
        nops(4);

        c = cyc;
        exp_at(c + 2, "redir_stall", STALL, 0);
        exp_at(c + 2, "redir_flush", FLUSH, 1);
        exp_at(c + 3, "redir_flush_end", FLUSH, 0);
        exp_at(c + 3, "redir_ex_asel", ASEL, 0);
        exp_at(c + 3, "redir_ex_bsel", BSEL, 0);
        exp_at(c + 3, "redir_link_wen", WEN, 1);
        exp_at(c + 3, "redir_link_rfw", WIDX, 1);
        exp_at(c + 4, "redir_lw_wen", WEN, 0);
        exp_at(c + 5, "redir_add_wen", WEN, 0);
        ins(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        lw(8, 3);
        ins(1, 8, 2, 1, 1, 9, 1, 0, 0, 0, 1);
        nops(5);

        c = cyc;
        exp_reset(c + 3, "rst_stall");
        exp_at(c + 4, "rst_stall_wen1", WEN, 0);
        exp_at(c + 5, "rst_stall_wen2", WEN, 0);
        add(13, 1, 2);
        lw(8, 3);
        rst_n = 1'b0;
        add(9, 8, 2);
        rst_n = 1'b1;
        nops(6);

        check("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
